// File: rtl/bit_serial_adder.sv
// ============================================================================
// Module   : bit_serial_adder
// Brief    : WIDTH-bit adder that uses one full-adder slice and a carry flop.
//            It adds LSB-first at one bit per clock and gives a registered
//            result together with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic w_sum_bit;
    logic w_carry_bit;

    // Full-adder slice: operates on the current LSBs and the stored carry
    assign w_sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign w_carry_bit = (a_sr_q[0] & b_sr_q[0]) | ((a_sr_q[0] ^ b_sr_q[0]) & carry_q);

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                sum_sr_d = {w_sum_bit, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = w_carry_bit;
                cnt_d    = cnt_q + CNT_ONE;
                // The final bit enters the result directly, so there is no extra cycle
                if (cnt_q == LAST_CNT) begin
                    sum_d   = {w_sum_bit, sum_sr_q[WIDTH-1:1]};
                    cout_d  = w_carry_bit;
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy_o = (state_q == S_SHIFT);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
// ============================================================================
// Module   : tb_bit_serial_adder
// Brief    : Self-checking bench for bit_serial_adder. It runs directed cases
//            and random sums for WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int n_checks = 0;
    int n_errors = 0;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .cin_i   (cin8),
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .cout_o  (cout8)
    );

    bit_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start16),
        .a_i     (a16),
        .b_i     (b16),
        .cin_i   (cin16),
        .busy_o  (busy16),
        .done_o  (done16),
        .sum_o   (sum16),
        .cout_o  (cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] result_of(input bit w16);
        return w16 ? {cout16, sum16} : {8'b0, cout8, sum8};
    endfunction

    function automatic logic done_of(input bit w16);
        return w16 ? done16 : done8;
    endfunction

    function automatic logic busy_of(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction

    // A single pulse on start. Checks the latency, the busy length and that the
    // result holds. It returns {cout,sum} as seen in the done cycle.
    task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input bit scramble, output logic [16:0] res);
        logic [16:0] prev;
        int          n;
        int          nbusy;
        int          width;
        bit          held;
        width = w16 ? 16 : 8;
        prev  = result_of(w16);
        if (w16) begin a16 = a; b16 = b; cin16 = c; start16 = 1'b1; end
        else     begin a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = 1'b1; end
        tick();
        start8 = 1'b0; start16 = 1'b0;
        if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        end
        n = 0; nbusy = 0; held = 1'b1;
        while (!done_of(w16) && n < 4 * width) begin
            if (busy_of(w16)) nbusy++;
            if (result_of(w16) !== prev) held = 1'b0;
            tick();
            n++;
        end
        check(w16 ? "lat16" : "lat8", n, width);
        check(w16 ? "busy16" : "busy8", nbusy, width);
        check(w16 ? "hold16" : "hold8", held, 1'b1);
        res = result_of(w16);
        tick();
        check(w16 ? "done_pulse16" : "done_pulse8", done_of(w16), 1'b0);
    endtask

    initial begin : main
        logic [16:0] res;
        logic [16:0] exp;
        logic [15:0] ra, rb;
        logic        rc;
        int          ndone;
        int          last;
        int          n;

        rst_n = 1'b1;
        start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        start16 = 0; a16 = '0; b16 = '0; cin16 = 0;
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_sum", sum8, 8'h00);
        check("rst_cout", cout8, 1'b0);
        check("rst_res16", {busy16, done16, cout16, sum16}, 19'h0);
        rst_n = 1'b1;
        tick();

        run_op(1'b0, 16'h5A, 16'h3C, 1'b0, 1'b0, res);
        check("t1_sum", res, 17'h096);
        tick(); tick();
        check("t1_hold", result_of(1'b0), 17'h096);

        run_op(1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, res);
        check("t2_ovf", res, 17'h100);
        run_op(1'b0, 16'hFF, 16'hFF, 1'b1, 1'b0, res);
        check("t2_max", res, 17'h1FF);

        // A second start during SHIFT must be ignored
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'hF0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin tick(); n++; end
        check("t3_lat", n, 5);
        check("t3_sum", {cout8, sum8}, 9'h002);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) ndone++;
        end
        check("t3_no_extra_done", ndone, 0);
        check("t3_idle", busy8, 1'b0);

        // Reset asserted in the middle of an operation
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("t4_abort", {busy8, done8, cout8, sum8}, 11'h0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8) ndone++;
        end
        check("t4_no_done", ndone, 0);
        rst_n = 1'b1;
        tick();
        run_op(1'b0, 16'h10, 16'h20, 1'b0, 1'b0, res);
        check("t4_sum", res, 17'h030);

        // Start held high continuously gives back-to-back operations
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        ndone = 0; last = -1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done8) begin
                if (last >= 0) check("t5_spacing", i - last, 9);
                check("t5_sum", {cout8, sum8}, 9'h007);
                last = i;
                ndone++;
            end
        end
        check("t5_count", ndone, 5);
        start8 = 1'b0;
        tick(); tick();

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            exp = 17'({9'b0, ra[7:0]} + {9'b0, rb[7:0]} + 17'(rc));
            run_op(1'b0, ra, rb, rc, (i % 2) == 1, res);
            check("rand8", res, exp);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            run_op(1'b1, ra, rb, rc, (i % 2) == 1, res);
            check("rand16", res, exp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
